// File: rtl/spdif_tx.sv
// S/PDIF (IEC 60958 consumer) transmitter.
// Accepts stereo 24-bit PCM pairs over valid/ready and emits a biphase-mark
// coded line, one half-bit cell per external cell_strobe (128 cells per frame).
// Ports:
//   clk_in        - sole clock
//   rst_n         - asynchronous active-low reset
//   cell_strobe   - one-clk pulse per BMC cell
//   sample_left   - left sample, two's complement, 24 bit
//   sample_right  - right sample
//   sample_valid  - sample pair offered
//   sample_ready  - holding register empty
//   spdif_out     - registered BMC line output
//   block_start   - one-clk pulse when cell 0 of frame 0 is emitted
//   underrun      - one-clk pulse when a frame starts with no sample held
module spdif_tx #(
  parameter logic [31:0] CS_WORD = 32'h0200_0004
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic        cell_strobe,
  input  logic [23:0] sample_left,
  input  logic [23:0] sample_right,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        spdif_out,
  output logic        block_start,
  output logic        underrun
);

  localparam int unsigned SAMPLE_W   = 24;
  localparam int unsigned CELL_W     = 7;
  localparam int unsigned FRAME_W    = 8;
  localparam int unsigned FRAME_LAST = 191;
  localparam int unsigned CS_FRAMES  = 32;

  // Preamble cell patterns for a previous line level of 0, first cell in bit 7.
  localparam logic [7:0] PRE_B = 8'b1110_1000;
  localparam logic [7:0] PRE_M = 8'b1110_0010;
  localparam logic [7:0] PRE_W = 8'b1110_0100;

  logic [CELL_W-1:0]   cell_q,   cell_d;
  logic [FRAME_W-1:0]  frame_q,  frame_d;
  logic [SAMPLE_W-1:0] hold_l_q, hold_l_d;
  logic [SAMPLE_W-1:0] hold_r_q, hold_r_d;
  logic                full_q,   full_d;
  logic [SAMPLE_W-1:0] act_l_q,  act_l_d;
  logic [SAMPLE_W-1:0] act_r_q,  act_r_d;
  logic                act_v_q,  act_v_d;
  logic                spdif_q,  spdif_d;
  logic                inv_q,    inv_d;
  logic                ready_q,  ready_d;
  logic                block_start_q, block_start_d;
  logic                underrun_q,    underrun_d;

  logic [4:0]          slot;
  logic [4:0]          sidx;
  logic                half;
  logic                sub_first;
  logic [SAMPLE_W-1:0] cur_sample;
  logic                c_bit;
  logic                p_bit;
  logic                data_bit;
  logic [7:0]          pre_pat;
  logic                pre_bit;
  logic                inv_use;

  assign slot       = cell_q[5:1];
  assign half       = cell_q[0];
  assign sub_first  = (cell_q[5:0] == 6'd0);
  assign cur_sample = cell_q[6] ? act_r_q : act_l_q;

  // Channel status is carried only in the first 32 frames of the block.
  assign c_bit = (frame_q < FRAME_W'(CS_FRAMES)) ? CS_WORD[frame_q[4:0]] : 1'b0;

  // Even parity over audio, V, U (always 0) and C.
  assign p_bit = ^{cur_sample, act_v_q, c_bit};

  // Preamble pattern and the inversion to apply; the flag is captured at the
  // first cell so the whole 8-cell pattern follows the level it started from.
  assign pre_pat = cell_q[6] ? PRE_W : ((frame_q == '0) ? PRE_B : PRE_M);
  assign pre_bit = 1'(pre_pat >> (3'd7 - cell_q[2:0]));
  assign inv_use = sub_first ? spdif_q : inv_q;

  // Payload bit for the current slot (only meaningful for slots 4..31).
  always_comb begin
    sidx = 5'(slot - 5'd4);
    case (slot)
      5'd28:   data_bit = act_v_q;
      5'd29:   data_bit = 1'b0;
      5'd30:   data_bit = c_bit;
      5'd31:   data_bit = p_bit;
      default: data_bit = 1'(cur_sample >> sidx);
    endcase
  end

  // Next-state: counters, buffering, BMC line and pulse outputs.
  always_comb begin
    cell_d        = cell_q;
    frame_d       = frame_q;
    hold_l_d      = hold_l_q;
    hold_r_d      = hold_r_q;
    full_d        = full_q;
    act_l_d       = act_l_q;
    act_r_d       = act_r_q;
    act_v_d       = act_v_q;
    spdif_d       = spdif_q;
    inv_d         = inv_q;
    block_start_d = 1'b0;
    underrun_d    = 1'b0;

    if (cell_strobe) begin
      cell_d = cell_q + CELL_W'(1);
      if (cell_q == CELL_W'(127)) begin
        frame_d = (frame_q == FRAME_W'(FRAME_LAST)) ? '0 : frame_q + FRAME_W'(1);
      end

      if (sub_first) begin
        inv_d = spdif_q;
      end

      if (slot < 5'd4) begin
        spdif_d = pre_bit ^ inv_use;
      end else if (!half) begin
        spdif_d = ~spdif_q;
      end else begin
        spdif_d = spdif_q ^ data_bit;
      end

      // Frame start: move holding to active, or substitute invalid silence.
      if (cell_q == '0) begin
        block_start_d = (frame_q == '0);
        if (full_q) begin
          act_l_d = hold_l_q;
          act_r_d = hold_r_q;
          act_v_d = 1'b0;
        end else begin
          act_l_d    = '0;
          act_r_d    = '0;
          act_v_d    = 1'b1;
          underrun_d = 1'b1;
        end
        full_d = 1'b0;
      end
    end

    // A handshake here fills holding for the next frame, never the current one.
    if (sample_valid && !full_q) begin
      hold_l_d = sample_left;
      hold_r_d = sample_right;
      full_d   = 1'b1;
    end

    ready_d = ~full_d;
  end

  // State register.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cell_q        <= '0;
      frame_q       <= '0;
      hold_l_q      <= '0;
      hold_r_q      <= '0;
      full_q        <= 1'b0;
      act_l_q       <= '0;
      act_r_q       <= '0;
      act_v_q       <= 1'b0;
      spdif_q       <= 1'b0;
      inv_q         <= 1'b0;
      ready_q       <= 1'b1;
      block_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      cell_q        <= cell_d;
      frame_q       <= frame_d;
      hold_l_q      <= hold_l_d;
      hold_r_q      <= hold_r_d;
      full_q        <= full_d;
      act_l_q       <= act_l_d;
      act_r_q       <= act_r_d;
      act_v_q       <= act_v_d;
      spdif_q       <= spdif_d;
      inv_q         <= inv_d;
      ready_q       <= ready_d;
      block_start_q <= block_start_d;
      underrun_q    <= underrun_d;
    end
  end

  assign sample_ready = ready_q;
  assign spdif_out    = spdif_q;
  assign block_start  = block_start_q;
  assign underrun     = underrun_q;

endmodule

// File: tb/tb_spdif_tx.sv
// Self-checking bench for spdif_tx: cycle-level reference model that builds
// whole subframe waveforms from the frame format, plus directed frame tests.
module tb_spdif_tx;

  logic        clk_in = 1'b0;
  logic        rst_n = 1'b0;
  logic        cell_strobe = 1'b0;
  logic [23:0] sample_left = '0;
  logic [23:0] sample_right = '0;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic        spdif_out;
  logic        block_start;
  logic        underrun;

  spdif_tx dut (
    .clk_in       (clk_in),
    .rst_n        (rst_n),
    .cell_strobe  (cell_strobe),
    .sample_left  (sample_left),
    .sample_right (sample_right),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .spdif_out    (spdif_out),
    .block_start  (block_start),
    .underrun     (underrun)
  );

  always #5 clk_in = ~clk_in;

  localparam logic [31:0] CS  = 32'h0200_0004;
  localparam logic [7:0]  P_B = 8'b1110_1000;
  localparam logic [7:0]  P_M = 8'b1110_0010;
  localparam logic [7:0]  P_W = 8'b1110_0100;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  int          m_cell, m_frame;
  bit          m_full, m_v, m_line;
  logic [23:0] m_hl, m_hr, m_al, m_ar;
  bit          wave[64];

  // stimulus feed
  bit          offer_v = 0;
  logic [23:0] offer_l, offer_r;
  logic [47:0] feed_q[$];
  bit          feed_rand = 0;

  // observation
  logic        dut_cells[128];
  logic        dut_frame_pre, sub_pre;
  int          strobe_cnt = 0;
  int          n_under = 0;
  int          bs_log[$];
  logic [23:0] dec_l, dec_r;
  logic        dec_vl, dec_vr, dec_pl, dec_pr, dec_cl, dec_cr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Whole-subframe waveform from the frame format and the previous line level.
  task automatic build_sub(input bit right, input int frame, input logic [23:0] s,
                           input bit v, input bit prev);
    bit bits[32];
    bit p, lvl;
    logic [7:0] pat;
    for (int i = 0; i < 32; i++) bits[i] = 0;
    for (int i = 0; i < 24; i++) bits[4+i] = s[i];
    bits[28] = v;
    bits[29] = 0;
    bits[30] = (frame < 32) ? CS[frame] : 1'b0;
    p = 0;
    for (int k = 4; k <= 30; k++) p ^= bits[k];
    bits[31] = p;
    pat = right ? P_W : ((frame == 0) ? P_B : P_M);
    for (int k = 0; k < 8; k++) wave[k] = pat[7-k] ^ prev;
    lvl = wave[7];
    for (int sl = 4; sl < 32; sl++) begin
      lvl = !lvl;
      wave[2*sl] = lvl;
      if (bits[sl]) lvl = !lvl;
      wave[2*sl+1] = lvl;
    end
  endtask

  function automatic logic dbit(input int base, input int s);
    return dut_cells[base+2*s+1] ^ dut_cells[base+2*s];
  endfunction

  // Decode the frame just emitted by the DUT and check preambles and C.
  task automatic frame_decode(input int fe);
    logic [7:0] got;
    logic [23:0] smp;
    logic pre_lvl;
    for (int side = 0; side < 2; side++) begin
      pre_lvl = side ? dut_cells[63] : dut_frame_pre;
      for (int k = 0; k < 8; k++) got[7-k] = dut_cells[side*64+k] ^ pre_lvl;
      chk(side ? "preamble_w" : "preamble_bm", got,
          side ? P_W : ((fe == 0) ? P_B : P_M));
      for (int i = 0; i < 24; i++) smp[i] = dbit(side*64, 4+i);
      if (side == 0) begin
        dec_l = smp; dec_vl = dbit(0, 28); dec_cl = dbit(0, 30); dec_pl = dbit(0, 31);
      end else begin
        dec_r = smp; dec_vr = dbit(64, 28); dec_cr = dbit(64, 30); dec_pr = dbit(64, 31);
      end
    end
    chk("c_slot_left",  dec_cl, (fe == 2 || fe == 25));
    chk("c_slot_right", dec_cr, (fe == 2 || fe == 25));
  endtask

  // One clock cycle with the model advanced alongside the DUT.
  task automatic cyc(input bit stb);
    logic pre;
    bit acc, exp_bs, exp_un;
    int ce, fe;
    @(negedge clk_in);
    if (!offer_v) begin
      if (feed_q.size() > 0) begin
        {offer_l, offer_r} = feed_q.pop_front();
        offer_v = 1;
      end else if (feed_rand) begin
        offer_l = 24'($urandom);
        offer_r = 24'($urandom);
        offer_v = 1;
      end
    end
    cell_strobe  = stb;
    sample_valid = offer_v;
    sample_left  = offer_l;
    sample_right = offer_r;
    #1;
    chk("sample_ready", sample_ready, !m_full);
    pre = spdif_out;
    acc = offer_v && !m_full;
    @(posedge clk_in);
    exp_bs = 0; exp_un = 0; ce = -1; fe = m_frame;
    if (stb) begin
      strobe_cnt++;
      ce = m_cell;
      if (m_cell == 0) begin
        if (m_full) begin m_al = m_hl; m_ar = m_hr; m_v = 0; end
        else begin m_al = 0; m_ar = 0; m_v = 1; exp_un = 1; end
        m_full = 0;
        exp_bs = (m_frame == 0);
        dut_frame_pre = pre;
      end
      if (m_cell % 64 == 0) begin
        build_sub(m_cell >= 64, m_frame, (m_cell >= 64) ? m_ar : m_al, m_v, m_line);
        sub_pre = pre;
      end
      m_line = wave[m_cell % 64];
      m_cell = (m_cell + 1) % 128;
      if (ce == 127) m_frame = (m_frame + 1) % 192;
    end
    if (acc) begin
      m_hl = offer_l; m_hr = offer_r; m_full = 1; offer_v = 0;
    end
    #1;
    chk("spdif_out", spdif_out, m_line);
    chk("block_start", block_start, exp_bs);
    chk("underrun", underrun, exp_un);
    if (underrun === 1'b1) n_under++;
    if (block_start === 1'b1) bs_log.push_back(strobe_cnt);
    if (ce >= 0) begin
      dut_cells[ce] = spdif_out;
      if (ce == 63 || ce == 127) chk("subframe_end_level", spdif_out, sub_pre);
      if (ce == 127) frame_decode(fe);
    end
  endtask

  task automatic run_strobes(input int n, input int maxgap);
    for (int i = 0; i < n; i++) begin
      cyc(1);
      repeat ($urandom_range(maxgap, 1)) cyc(0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst_n = 0;
    cell_strobe = 0;
    sample_valid = 0;
    offer_v = 0;
    feed_q.delete();
    feed_rand = 0;
    #1;
    chk("rst_spdif_out", spdif_out, 1'b0);
    chk("rst_sample_ready", sample_ready, 1'b1);
    chk("rst_block_start", block_start, 1'b0);
    chk("rst_underrun", underrun, 1'b0);
    m_cell = 0; m_frame = 0; m_full = 0; m_v = 0; m_line = 0;
    m_al = 0; m_ar = 0; m_hl = 0; m_hr = 0;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_n = 1;
  endtask

  function automatic logic [7:0] first8();
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[7-k] = dut_cells[k];
    return r;
  endfunction

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
    bit          pl;
    bit          pr;
    bit          c;
  } vec_t;

  initial begin
    vec_t tbl[4];
    int u0, b0;
    tbl[0] = '{l: 24'h000001, r: 24'h800000, pl: 1, pr: 1, c: 0};
    tbl[1] = '{l: 24'h000003, r: 24'hFFFFFF, pl: 0, pr: 0, c: 0};
    tbl[2] = '{l: 24'h000000, r: 24'h000007, pl: 1, pr: 0, c: 1};
    tbl[3] = '{l: 24'hABCDEF, r: 24'h123456, pl: 1, pr: 1, c: 0};

    // No samples: two underrunning frames of silence with V set.
    do_reset();
    u0 = n_under;
    for (int f = 0; f < 2; f++) begin
      run_strobes(128, 3);
      if (f == 0) chk("idle_first_cells", first8(), 8'b1110_1000);
      chk("idle_left_zero", dec_l, 24'h0);
      chk("idle_right_zero", dec_r, 24'h0);
      chk("idle_v_left", dec_vl, 1'b1);
      chk("idle_v_right", dec_vr, 1'b1);
    end
    chk("idle_underrun_count", n_under - u0, 2);
    chk("idle_block_start_count", bs_log.size(), 1);

    // Table of sample pairs held ahead of each frame.
    do_reset();
    u0 = n_under;
    for (int i = 0; i < 4; i++) feed_q.push_back({tbl[i].l, tbl[i].r});
    repeat (2) cyc(0);
    for (int i = 0; i < 4; i++) begin
      run_strobes(128, 3);
      chk("tbl_left", dec_l, tbl[i].l);
      chk("tbl_right", dec_r, tbl[i].r);
      chk("tbl_p_left", dec_pl, tbl[i].pl);
      chk("tbl_p_right", dec_pr, tbl[i].pr);
      chk("tbl_c", dec_cl, tbl[i].c);
      chk("tbl_v", {dec_vl, dec_vr}, 2'b00);
    end
    chk("tbl_underrun_count", n_under - u0, 0);

    // Handshake on the same clk as the cell-0 strobe with holding empty.
    offer_l = 24'h5A5A5A;
    offer_r = 24'h0F0F0F;
    offer_v = 1;
    cyc(1);
    chk("hs_underrun", underrun, 1'b1);
    chk("hs_ready_low", sample_ready, 1'b0);
    cyc(0);
    run_strobes(127, 3);
    chk("hs_frame_v", {dec_vl, dec_vr}, 2'b11);
    chk("hs_frame_zero", {dec_l, dec_r}, 48'h0);
    cyc(1);
    chk("hs_next_no_underrun", underrun, 1'b0);
    chk("hs_ready_high", sample_ready, 1'b1);
    cyc(0);
    run_strobes(127, 3);
    chk("hs_next_left", dec_l, 24'h5A5A5A);
    chk("hs_next_right", dec_r, 24'h0F0F0F);
    chk("hs_next_v", {dec_vl, dec_vr}, 2'b00);

    // Reset mid-frame after cell 70, then a full block of random data.
    run_strobes(71, 2);
    do_reset();
    feed_rand = 1;
    bs_log.delete();
    u0 = n_under;
    b0 = strobe_cnt;
    repeat (2) cyc(0);
    for (int f = 0; f < 193; f++) begin
      run_strobes(128, 1);
      if (f == 0) chk("post_reset_first_cells", first8(), 8'b1110_1000);
    end
    chk("long_underrun_count", n_under - u0, 0);
    chk("long_block_start_count", bs_log.size(), 2);
    if (bs_log.size() == 2) begin
      chk("block_start_first", bs_log[0] - b0, 1);
      chk("block_start_period", bs_log[1] - bs_log[0], 24576);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
